// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- registered integer ALU for the RV32I datapath.
//
// One operation is sampled on every rising clk edge. Result and the Z/N/V/C
// flags appear on that same edge (latency 1, throughput 1, no handshake).
//
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous, active-low reset (clears all outputs)
//   A           in   WIDTH  operand A (rs1 / PC)
//   B           in   WIDTH  operand B (rs2 / immediate)
//   ALUControl  in   3      operation select (ADD SUB AND OR XOR SLT SLTU PASSB)
//   Result      out  WIDTH  registered result
//   Z           out  1      Result == 0
//   N           out  1      Result[WIDTH-1]
//   V           out  1      signed overflow (ADD/SUB only, else 0)
//   C           out  1      adder carry-out (ADD/SUB only, else 0)
// -----------------------------------------------------------------------------
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_SLT   = 3'b101,
        OP_SLTU  = 3'b110,
        OP_PASSB = 3'b111
    } alu_op_e;

    alu_op_e          op;
    logic             do_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    logic [WIDTH-1:0] result_d, result_q;
    logic             z_d, z_q;
    logic             n_d, n_q;
    logic             v_d, v_q;
    logic             c_d, c_q;

    assign op = alu_op_e'(ALUControl);

    // One shared adder: SUB, SLT and SLTU all evaluate A + ~B + 1.
    always_comb begin
        do_sub   = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        b_eff    = do_sub ? ~B : B;
        add_full = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, do_sub};
        sum      = add_full[WIDTH-1:0];
        carry    = add_full[WIDTH];
        // Same-sign adder inputs producing a different-sign sum.
        ovf      = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    end

    always_comb begin
        result_d = '0;
        v_d      = 1'b0;
        c_d      = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result_d = sum;
                v_d      = ovf;
                c_d      = carry;
            end
            OP_AND:   result_d = A & B;
            OP_OR:    result_d = A | B;
            OP_XOR:   result_d = A ^ B;
            // Signed less-than stays correct under overflow via N^V.
            OP_SLT:   result_d[0] = sum[WIDTH-1] ^ ovf;
            // Unsigned less-than is a borrow, i.e. no carry-out.
            OP_SLTU:  result_d[0] = ~carry;
            OP_PASSB: result_d = B;
            default:  result_d = '0;
        endcase
        z_d = (result_d == '0);
        n_d = result_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            c_q      <= c_d;
        end
    end

    assign Result = result_q;
    assign Z      = z_q;
    assign N      = n_q;
    assign V      = v_q;
    assign C      = c_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- directed-vector bench for alu with hand-computed expected values.
// Flags are compared as a packed {Z,N,V,C} nibble.
// -----------------------------------------------------------------------------
module tb_alu;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] result;
    logic             z, n, v, c;

    int unsigned n_compared;
    int unsigned n_mismatched;

    alu #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (a),
        .B          (b),
        .ALUControl (alu_control),
        .Result     (result),
        .Z          (z),
        .N          (n),
        .V          (v),
        .C          (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Apply one operation, clock it, then check result and {Z,N,V,C}.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] opa, input logic [31:0] opb,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags);
        a           = opa;
        b           = opb;
        alu_control = op;
        @(posedge clk);
        #1;
        check({tag, ".res"}, result, exp_res);
        check({tag, ".znvc"}, {28'd0, z, n, v, c}, {28'd0, exp_flags});
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        // Held in reset with live inputs: outputs stay clear across edges.
        rst         = 1'b0;
        a           = 32'd10;
        b           = 32'd20;
        alu_control = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst.res", result, 32'd0);
        check("rst.znvc", {28'd0, z, n, v, c}, 32'd0);

        // Release between edges; first edge loads 10+20.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel.res", result, 32'd30);

        // Operand sweep with A=10, B=20.
        run_op("add",  3'b000, 32'd10, 32'd20, 32'd30,         4'b0000);
        run_op("sub",  3'b001, 32'd10, 32'd20, 32'hFFFF_FFF6,  4'b0100);
        run_op("and",  3'b010, 32'd10, 32'd20, 32'd0,          4'b1000);
        run_op("or",   3'b011, 32'd10, 32'd20, 32'd30,         4'b0000);
        run_op("xor",  3'b100, 32'd10, 32'd20, 32'd30,         4'b0000);
        run_op("slt",  3'b101, 32'd10, 32'd20, 32'd1,          4'b0000);

        // Input changes between edges must not reach the outputs.
        a           = 32'hDEAD_BEEF;
        b           = 32'h0000_0001;
        alu_control = 3'b111;
        #2;
        check("hold.res", result, 32'd1);

        // Overflow / carry boundaries.
        run_op("add_ovf",  3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0110);
        run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0,         4'b1001);
        run_op("sub_ovf",  3'b001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011);
        run_op("slt_ovf",  3'b101, 32'h8000_0000, 32'd1, 32'd1,         4'b0000);
        run_op("sltu_ge",  3'b110, 32'h8000_0000, 32'd1, 32'd0,         4'b1000);
        run_op("sltu_lt",  3'b110, 32'd1, 32'hFFFF_FFFF, 32'd1,         4'b0000);
        run_op("slt_ge",   3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0,         4'b1000);
        run_op("passb",    3'b111, 32'h0000_0005, 32'h1234_5000, 32'h1234_5000, 4'b0000);
        run_op("passb_n",  3'b111, 32'h0000_0005, 32'h8000_0000, 32'h8000_0000, 4'b0100);
        run_op("sub_eq",   3'b001, 32'd5, 32'd5, 32'd0,                 4'b1001);
        run_op("or_neg",   3'b011, 32'h8000_0000, 32'h0000_00F0, 32'h8000_00F0, 4'b0100);

        // Load a nonzero result, then assert reset between edges.
        run_op("pre_rst",  3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0110);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst.res", result, 32'd0);
        check("async_rst.znvc", {28'd0, z, n, v, c}, 32'd0);

        // Recover after reset.
        @(negedge clk);
        rst = 1'b1;
        run_op("post_rst", 3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
